// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if
//   Unified memory-port handshake between the multi-cycle sequencer and the
//   shared instruction/data memory.
//
//   Signals:
//     mem_req  - request, held stable until mem_ack       (sequencer -> mem)
//     mem_wr   - write qualifier, meaningful with mem_req (sequencer -> mem)
//     i_or_d   - address select: 0 = PC, 1 = ALU out reg  (sequencer -> mem)
//     mem_ack  - request completes this cycle             (mem -> sequencer)
//
//   Modports: master (sequencer side), slave (memory side).
// ---------------------------------------------------------------------------
interface mc_sequencer_if;
  logic mem_req;
  logic mem_wr;
  logic i_or_d;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_wr,
    output i_or_d,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  i_or_d,
    output mem_ack
  );
endinterface

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle control sequencer for the CPU datapath. Walks each instruction
//   through IDLE/FETCH/DECODE/EXEC/MEM/WB, sharing one memory port between
//   instruction and data accesses via a req/ack handshake, and keeps a
//   saturating retired-instruction counter.
//
//   Parameter:
//     CNT_W      - width of the retired-instruction counter
//
//   Ports:
//     clk, rst   - clock (rising edge), synchronous active-high reset
//     op, fun    - Inst[31:26], Inst[5:0] from the instruction register
//     equal,sign - ALU zero flag and ALU result bit 31
//     mem        - memory handshake (mc_sequencer_if.master)
//     ir_wr, pc_wr, pc_src, reg_wr, reg_dst, ext_op, alu_src, alu_ctr,
//     mem_to_reg - datapath controls
//     state      - current state (debug)
//     retired    - saturating retired-instruction count
//     halted     - illegal-instruction trap indicator
//
//   Build option:
//     MC_ILLEGAL_TRAP_EN - when defined, an unsupported instruction traps
//     into HALT (halted=1) until reset; otherwise it retires as a NOP and
//     halted is tied to 0.
// ---------------------------------------------------------------------------
module mc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        fun,
  input  logic              equal,
  input  logic              sign,
  mc_sequencer_if.master    mem,
  output logic              ir_wr,
  output logic              pc_wr,
  output logic              pc_src,
  output logic              reg_wr,
  output logic              reg_dst,
  output logic              ext_op,
  output logic              alu_src,
  output logic [2:0]        alu_ctr,
  output logic              mem_to_reg,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  retired,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE = 3'd0,
    C_ADDI  = 3'd1,
    C_LW    = 3'd2,
    C_SW    = 3'd3,
    C_BEQ   = 3'd4,
    C_BNE   = 3'd5,
    C_BGTZ  = 3'd6,
    C_ILL   = 3'd7
  } cls_t;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_ADDU = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  // R-type function code to ALU operation; valid only when rfun_ok is true.
  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'h20:   rtype_alu = ALU_ADD;
      6'h21:   rtype_alu = ALU_ADDU;
      6'h22:   rtype_alu = ALU_SUB;
      6'h23:   rtype_alu = ALU_SUB;
      6'h24:   rtype_alu = ALU_AND;
      6'h25:   rtype_alu = ALU_OR;
      6'h00:   rtype_alu = ALU_SLL;
      6'h2A:   rtype_alu = ALU_SLT;
      6'h2B:   rtype_alu = ALU_SLTU;
      default: rtype_alu = ALU_AND;
    endcase
  endfunction

  function automatic logic rfun_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
      6'h25, 6'h00, 6'h2A, 6'h2B: rfun_ok = 1'b1;
      default:                    rfun_ok = 1'b0;
    endcase
  endfunction

  function automatic cls_t decode_cls(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:   decode_cls = rfun_ok(f) ? C_RTYPE : C_ILL;
      6'h08:   decode_cls = C_ADDI;
      6'h23:   decode_cls = C_LW;
      6'h2B:   decode_cls = C_SW;
      6'h04:   decode_cls = C_BEQ;
      6'h05:   decode_cls = C_BNE;
      6'h07:   decode_cls = C_BGTZ;
      default: decode_cls = C_ILL;
    endcase
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  cls_t              cls_q, cls_d;
  logic [2:0]        rfn_alu_q, rfn_alu_d;
  cls_t              dec_cls;
  logic              br_taken;

  assign dec_cls = decode_cls(op, fun);

  // Class and R-type ALU code are captured once, in DECODE, and then drive
  // the Moore outputs of the following states. They need no reset because
  // nothing reads them before DECODE has written them.
  always_comb begin
    cls_d     = cls_q;
    rfn_alu_d = rfn_alu_q;
    if (state_q == S_DECODE) begin
      cls_d     = dec_cls;
      rfn_alu_d = rtype_alu(fun);
    end
  end

  always_comb begin
    case (cls_q)
      C_BEQ:   br_taken = equal;
      C_BNE:   br_taken = !equal;
      C_BGTZ:  br_taken = !equal && !sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    mem.mem_req = 1'b0;
    mem.mem_wr  = 1'b0;
    mem.i_or_d  = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = 1'b0;
    reg_wr      = 1'b0;
    reg_dst     = 1'b0;
    ext_op      = 1'b0;
    alu_src     = 1'b0;
    alu_ctr     = ALU_AND;
    mem_to_reg  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ext_op = (dec_cls == C_ADDI) || (dec_cls == C_LW) || (dec_cls == C_SW);
        if (dec_cls == C_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d   = S_FETCH;
          retired_d = sat_inc(retired_q);
`endif
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls_q)
          C_RTYPE: begin
            reg_dst = 1'b1;
            alu_ctr = rfn_alu_q;
            state_d = S_WB;
          end
          C_ADDI: begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            alu_ctr = ALU_ADD;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            alu_ctr = ALU_ADDU;
            state_d = S_MEM;
          end
          C_BEQ, C_BNE, C_BGTZ: begin
            alu_ctr   = ALU_SUB;
            pc_wr     = br_taken;
            pc_src    = br_taken;
            state_d   = S_FETCH;
            retired_d = sat_inc(retired_q);
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.i_or_d  = 1'b1;
        mem.mem_wr  = (cls_q == C_SW);
        if (mem.mem_ack) begin
          if (cls_q == C_SW) begin
            state_d   = S_FETCH;
            retired_d = sat_inc(retired_q);
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = (cls_q == C_RTYPE);
        mem_to_reg = (cls_q == C_LW);
        // ALU inputs stay as in EXEC so the write-back value does not move.
        case (cls_q)
          C_RTYPE: alu_ctr = rfn_alu_q;
          C_ADDI: begin
            alu_ctr = ALU_ADD;
            alu_src = 1'b1;
            ext_op  = 1'b1;
          end
          C_LW: begin
            alu_ctr = ALU_ADDU;
            alu_src = 1'b1;
            ext_op  = 1'b1;
          end
          default: alu_ctr = ALU_AND;
        endcase
        state_d   = S_FETCH;
        retired_d = sat_inc(retired_q);
      end

`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    cls_q     <= cls_d;
    rfn_alu_q <= rfn_alu_d;
  end

  assign state   = state_q;
  assign retired = retired_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//   Directed bench for mc_sequencer. A second instance with CNT_W=2 runs in
//   lockstep on the same stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  fun;
  logic        equal;
  logic        sign;
  logic        ack;

  logic        ir_wr, pc_wr, pc_src, reg_wr, reg_dst, ext_op, alu_src, mem_to_reg;
  logic [2:0]  alu_ctr, state;
  logic [15:0] retired;
  logic        halted;

  logic        ir_wr2, pc_wr2, pc_src2, reg_wr2, reg_dst2, ext_op2, alu_src2, mem_to_reg2;
  logic [2:0]  alu_ctr2, state2;
  logic [1:0]  retired2;
  logic        halted2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int cyc_start;

  mc_sequencer_if mif ();
  mc_sequencer_if mif2 ();

  assign mif.mem_ack  = ack;
  assign mif2.mem_ack = ack;

  mc_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .op(op), .fun(fun), .equal(equal), .sign(sign),
    .mem(mif), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .ext_op(ext_op), .alu_src(alu_src), .alu_ctr(alu_ctr),
    .mem_to_reg(mem_to_reg), .state(state), .retired(retired), .halted(halted)
  );

  mc_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .op(op), .fun(fun), .equal(equal), .sign(sign),
    .mem(mif2), .ir_wr(ir_wr2), .pc_wr(pc_wr2), .pc_src(pc_src2), .reg_wr(reg_wr2),
    .reg_dst(reg_dst2), .ext_op(ext_op2), .alu_src(alu_src2), .alu_ctr(alu_ctr2),
    .mem_to_reg(mem_to_reg2), .state(state2), .retired(retired2), .halted(halted2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input logic a);
    ack = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ack = 1'b0; op = 6'h00; fun = 6'h00; equal = 1'b0; sign = 1'b0;
    nxt(); nxt();
    rst = 1'b0; #1;

    // Reset state
    check_val("rst_state",   state, 0);
    check_val("rst_retired", retired, 0);
    check_val("rst_req",     mif.mem_req, 0);
    check_val("rst_halted",  halted, 0);
    check_val("rst_regwr",   reg_wr, 0);
    check_val("rst_retired2", retired2, 0);

    // add with zero-wait memory: 0,1,2,3,5,1
    op = 6'h00; fun = 6'h20; ack = 1'b1;
    nxt();
    check_val("add_f_state", state, 1);
    check_val("add_f_req",   mif.mem_req, 1);
    check_val("add_f_iord",  mif.i_or_d, 0);
    check_val("add_f_irwr",  ir_wr, 1);
    check_val("add_f_pcwr",  pc_wr, 1);
    check_val("add_f_pcsrc", pc_src, 0);
    nxt();
    check_val("add_d_state", state, 2);
    check_val("add_d_ext",   ext_op, 0);
    nxt();
    check_val("add_e_state", state, 3);
    check_val("add_e_alu",   alu_ctr, 2);
    check_val("add_e_dst",   reg_dst, 1);
    check_val("add_e_src",   alu_src, 0);
    check_val("add_e_regwr", reg_wr, 0);
    nxt();
    check_val("add_w_state", state, 5);
    check_val("add_w_regwr", reg_wr, 1);
    check_val("add_w_dst",   reg_dst, 1);
    check_val("add_w_alu",   alu_ctr, 2);
    check_val("add_w_m2r",   mem_to_reg, 0);
    check_val("add_w_pcwr",  pc_wr, 0);
    check_val("add_w_req",   mif.mem_req, 0);
    nxt();
    check_val("add_ret_state", state, 1);
    check_val("add_retired",   retired, 1);

    // lw with two wait cycles in FETCH and in MEM
    op = 6'h23; cyc_start = cyc_cnt;
    set_ack(1'b0);
    check_val("lw_f1_req",  mif.mem_req, 1);
    check_val("lw_f1_irwr", ir_wr, 0);
    check_val("lw_f1_pcwr", pc_wr, 0);
    nxt();
    check_val("lw_f2_state", state, 1);
    check_val("lw_f2_req",   mif.mem_req, 1);
    check_val("lw_f2_iord",  mif.i_or_d, 0);
    nxt();
    set_ack(1'b1);
    check_val("lw_f3_state", state, 1);
    check_val("lw_f3_irwr",  ir_wr, 1);
    nxt();
    check_val("lw_d_state", state, 2);
    check_val("lw_d_ext",   ext_op, 1);
    nxt();
    check_val("lw_e_alu", alu_ctr, 4);
    check_val("lw_e_src", alu_src, 1);
    check_val("lw_e_ext", ext_op, 1);
    nxt();
    set_ack(1'b0);
    check_val("lw_m1_state", state, 4);
    check_val("lw_m1_req",   mif.mem_req, 1);
    check_val("lw_m1_iord",  mif.i_or_d, 1);
    check_val("lw_m1_wr",    mif.mem_wr, 0);
    check_val("lw_m1_regwr", reg_wr, 0);
    nxt();
    check_val("lw_m2_state", state, 4);
    check_val("lw_m2_req",   mif.mem_req, 1);
    check_val("lw_m2_iord",  mif.i_or_d, 1);
    nxt();
    set_ack(1'b1);
    check_val("lw_m3_state", state, 4);
    nxt();
    check_val("lw_w_state", state, 5);
    check_val("lw_w_m2r",   mem_to_reg, 1);
    check_val("lw_w_regwr", reg_wr, 1);
    check_val("lw_w_dst",   reg_dst, 0);
    check_val("lw_w_req",   mif.mem_req, 0);
    nxt();
    check_val("lw_state",   state, 1);
    check_val("lw_cycles",  cyc_cnt - cyc_start, 9);
    check_val("lw_retired", retired, 2);

    // beq taken (equal=1)
    op = 6'h04; equal = 1'b1; sign = 1'b0;
    nxt(); nxt();
    check_val("beq_e_state", state, 3);
    check_val("beq_e_pcwr",  pc_wr, 1);
    check_val("beq_e_pcsrc", pc_src, 1);
    check_val("beq_e_alu",   alu_ctr, 6);
    check_val("beq_e_src",   alu_src, 0);
    nxt();
    check_val("beq_state",   state, 1);
    check_val("beq_retired", retired, 3);

    // bne not taken (equal=1)
    op = 6'h05;
    nxt(); nxt();
    check_val("bne_e_pcwr",  pc_wr, 0);
    check_val("bne_e_pcsrc", pc_src, 0);
    check_val("bne_e_alu",   alu_ctr, 6);
    nxt();
    check_val("bne_retired", retired, 4);

    // bgtz not taken (sign=1), then taken (positive)
    op = 6'h07; equal = 1'b0; sign = 1'b1;
    nxt(); nxt();
    check_val("bgtz_neg_pcwr", pc_wr, 0);
    nxt();
    check_val("bgtz_neg_retired", retired, 5);
    sign = 1'b0;
    nxt(); nxt();
    check_val("bgtz_pos_pcwr",  pc_wr, 1);
    check_val("bgtz_pos_pcsrc", pc_src, 1);
    nxt();
    check_val("bgtz_pos_retired", retired, 6);

    // sw with one MEM wait cycle
    op = 6'h2B;
    check_val("sw_f_wr", mif.mem_wr, 0);
    nxt();
    check_val("sw_d_ext", ext_op, 1);
    check_val("sw_d_wr",  mif.mem_wr, 0);
    nxt();
    check_val("sw_e_alu",   alu_ctr, 4);
    check_val("sw_e_src",   alu_src, 1);
    check_val("sw_e_wr",    mif.mem_wr, 0);
    nxt();
    set_ack(1'b0);
    check_val("sw_m1_state", state, 4);
    check_val("sw_m1_req",   mif.mem_req, 1);
    check_val("sw_m1_wr",    mif.mem_wr, 1);
    check_val("sw_m1_iord",  mif.i_or_d, 1);
    check_val("sw_m1_regwr", reg_wr, 0);
    set_ack(1'b1);
    check_val("sw_m2_wr",    mif.mem_wr, 1);
    check_val("sw_m2_regwr", reg_wr, 0);
    nxt();
    check_val("sw_state",   state, 1);
    check_val("sw_retired", retired, 7);
    check_val("sw_f_wr2",   mif.mem_wr, 0);

    // Reset during a MEM wait drops the request
    op = 6'h23;
    nxt(); nxt(); nxt();
    set_ack(1'b0);
    check_val("rstm_state", state, 4);
    check_val("rstm_req",   mif.mem_req, 1);
    rst = 1'b1;
    nxt();
    rst = 1'b0; #1;
    check_val("rstm_after_state",   state, 0);
    check_val("rstm_after_req",     mif.mem_req, 0);
    check_val("rstm_after_retired", retired, 0);
    check_val("rstm_after_ret2",    retired2, 0);

    // Unsupported opcode
    op = 6'h3F; ack = 1'b1;
    nxt(); nxt();
    check_val("ill_d_state", state, 2);
    nxt();
`ifdef MC_ILLEGAL_TRAP_EN
    check_val("ill_state",   state, 6);
    check_val("ill_halted",  halted, 1);
    check_val("ill_retired", retired, 0);
    check_val("ill_req",     mif.mem_req, 0);
    nxt();
    check_val("ill_hold_state", state, 6);
    check_val("ill_hold_pcwr",  pc_wr, 0);
`else
    check_val("ill_state",   state, 1);
    check_val("ill_halted",  halted, 0);
    check_val("ill_retired", retired, 1);
`endif
    rst = 1'b1;
    nxt();
    rst = 1'b0; #1;
    check_val("ill_rst_state",  state, 0);
    check_val("ill_rst_halted", halted, 0);

    // Five adds: 16-bit counter reaches 5, 2-bit counter holds at 3
    op = 6'h00; fun = 6'h20; ack = 1'b1;
    nxt();
    for (int i = 0; i < 5; i++) begin
      nxt(); nxt(); nxt(); nxt();
    end
    check_val("sat_state",    state, 1);
    check_val("sat_retired",  retired, 5);
    check_val("sat_retired2", retired2, 3);
    check_val("sat_state2",   state2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
